// File: rtl/line_mem_responder.sv
// line_mem_responder: single-outstanding 256-bit line memory with fixed response latency.
// One read or write is accepted at a time. Each transaction finishes with a one-cycle resp pulse.
module line_mem_responder #(
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned LATENCY = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [255:0] wdata,
    output logic         resp,
    output logic [255:0] rdata,
    output logic         proto_err
);

    localparam int unsigned DEPTH  = 2 ** IDX_W;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state;
    logic               op_write;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  mem [DEPTH];

    // Request level of the operation that was accepted; dropping it aborts the access.
    logic req_held_c;
    assign req_held_c = op_write ? write : read;

    // Offset bits and index-aliasing bits are intentionally ignored.
    logic unused_addr_bits_c;
    assign unused_addr_bits_c = ^{address[31:5+IDX_W], address[4:0]};

    // Transaction FSM with registered resp, rdata and sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            resp      <= 1'b0;
            rdata     <= '0;
            proto_err <= 1'b0;
        end else begin
            resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (read && write) begin
                        proto_err <= 1'b1;
                    end else if (read || write) begin
                        state    <= BUSY;
                        op_write <= write;
                        idx      <= address[5 +: IDX_W];
                        cnt      <= CNT_W'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (!req_held_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt <= CNT_W'(1)) begin
                        // A count of 0 only occurs with LATENCY==1 and still takes one BUSY edge.
                        state <= RESP;
                        resp  <= 1'b1;
                        cnt   <= '0;
                        if (!op_write) begin
                            rdata <= mem[idx];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line array; written on the edge leaving RESP, contents survive reset.
    always_ff @(posedge clk) begin
        if (state == RESP && op_write) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed and randomized checks of line_mem_responder against an associative-array line model.
module tb_line_mem_responder;

    localparam int unsigned IDX_W = 8;
    localparam int unsigned LAT   = 10;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         read    = 1'b0;
    logic         write   = 1'b0;
    logic [31:0]  address = '0;
    logic [255:0] wdata   = '0;
    logic         resp;
    logic [255:0] rdata;
    logic         proto_err;

    int nassert = 0;
    int nfail   = 0;

    logic [255:0] model_mem [int];
    logic [255:0] model_rdata = '0;
    logic         proto_m     = 1'b0;

    always #5 clk = ~clk;

    line_mem_responder #(
        .IDX_W   (IDX_W),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read      (read),
        .write     (write),
        .address   (address),
        .wdata     (wdata),
        .resp      (resp),
        .rdata     (rdata),
        .proto_err (proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line index from plain byte-address arithmetic: 32-byte lines, 2**IDX_W lines, wrapping.
    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % (2 ** IDX_W));
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // One transaction requested in cycle 0; abort_at>0 drops the request during that cycle.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [255:0] d,
                       input int abort_at, input string tag);
        int  ln;
        bit  done;
        ln   = line_of(addr);
        done = (abort_at == 0);
        read    = !wr;
        write   = wr;
        address = addr;
        wdata   = ~d;
        for (int c = 1; c <= int'(LAT) + 1; c++) begin
            tick();
            if (c == 1) address = $urandom();
            if (c == 2) wdata = d;
            if (abort_at != 0 && c == abort_at) begin
                read  = 1'b0;
                write = 1'b0;
            end
            if (c == int'(LAT) + 1) begin
                read  = 1'b0;
                write = 1'b0;
            end
            chk({tag, " resp"}, 256'(resp), 256'(done && c == int'(LAT)));
            if (done && !wr && c == int'(LAT)) model_rdata = model_mem[ln];
            if (c >= int'(LAT)) chk({tag, " rdata"}, rdata, model_rdata);
        end
        if (done && wr) model_mem[ln] = d;
        chk({tag, " proto_err"}, 256'(proto_err), 256'(proto_m));
    endtask

    initial begin
        logic [255:0] a5;
        logic [255:0] d;
        logic [31:0]  addr;
        int           ln;
        bit           wr;
        int           ab;

        a5 = {32{8'hA5}};

        // Reset values
        #2;
        chk("reset resp", 256'(resp), 256'(0));
        chk("reset rdata", rdata, 256'(0));
        chk("reset proto_err", 256'(proto_err), 256'(0));
        #10;
        rst_n = 1'b1;
        tick();

        // Write then read line A5 at 0x100
        txn(1'b1, 32'h0000_0100, a5, 0, "t1 wr");
        txn(1'b0, 32'h0000_0100, '0, 0, "t1 rd");
        chk("t1 data", rdata, a5);

        // Offset bits ignored
        d = rand_line();
        txn(1'b1, 32'h0000_0120, d, 0, "t2 wr");
        txn(1'b0, 32'h0000_013F, '0, 0, "t2 rd1f");
        txn(1'b0, 32'h0000_0120, '0, 0, "t2 rd00");
        chk("t2 data", rdata, d);

        // Aliasing modulo 8 KiB
        d = rand_line();
        txn(1'b1, 32'h0000_2000, d, 0, "t3 wr");
        txn(1'b0, 32'h0000_0000, '0, 0, "t3 rd");
        chk("t3 data", rdata, d);

        // Aborted write leaves the line untouched
        txn(1'b1, 32'h0000_0100, rand_line(), 4, "t4 wr abort");
        txn(1'b0, 32'h0000_0100, '0, 0, "t4 rd");
        chk("t4 data", rdata, a5);

        // Read and write together: sticky error, no access
        chk("t5 pre proto_err", 256'(proto_err), 256'(0));
        read  = 1'b1;
        write = 1'b1;
        tick();
        read  = 1'b0;
        write = 1'b0;
        proto_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t5 proto_err", 256'(proto_err), 256'(1));
            chk("t5 resp", 256'(resp), 256'(0));
            tick();
        end
        txn(1'b0, 32'h0000_0120, '0, 0, "t5 rd");

        // Reset in the middle of a write
        write   = 1'b1;
        address = 32'h0000_2000;
        wdata   = rand_line();
        for (int c = 1; c <= 5; c++) tick();
        rst_n = 1'b0;
        #1;
        chk("t6 resp", 256'(resp), 256'(0));
        chk("t6 rdata", rdata, 256'(0));
        chk("t6 proto_err", 256'(proto_err), 256'(0));
        write = 1'b0;
        #1;
        rst_n = 1'b1;
        proto_m = 1'b0;
        model_rdata = '0;
        tick();
        txn(1'b0, 32'h0000_0000, '0, 0, "t6 rd");
        chk("t6 data", rdata, model_mem[0]);

        // Randomized traffic over 16 lines with random upper address bits and occasional aborts
        for (int i = 0; i < 40; i++) begin
            ln   = int'($urandom_range(0, 15));
            addr = ($urandom() & 32'hFFFF_E000) | (32'(ln) << 5) | 32'($urandom_range(0, 31));
            wr   = ($urandom_range(0, 1) == 1) || !model_mem.exists(ln);
            ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LAT - 1)) : 0;
            txn(wr, addr, rand_line(), ab, wr ? "rnd wr" : "rnd rd");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
